layer_deser: RTL and testbench

LAYER_DESER -- requirements
Module: layer_deser

---
 rtl/net_pkg.sv | 16 +
 rtl/layer_deser_gap_timer.sv | 29 ++
 rtl/layer_deser.sv | 117 +++++++++++
 tb/tb_layer_deser.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/net_pkg.sv
// Shared definitions for the layer stream blocks: deserializer state encoding,
// default word width and the neuron count of each network layer.
package net_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    localparam int DATA_WIDTH     = 16;
    localparam int LAYER0_NEURONS = 30;
    localparam int LAYER1_NEURONS = 30;
    localparam int LAYER2_NEURONS = 10;
    localparam int LAYER3_NEURONS = 10;

endpackage

// File: rtl/layer_deser_gap_timer.sv
// Idle-gap watchdog for a partially collected frame. o_expire is high on the
// cycle that would be the timeout-th consecutive idle cycle inside a frame.
module layer_deser_gap_timer #(
    parameter int timeout = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_fill,
    input  logic i_valid,
    output logic o_expire
);

    localparam int GAP_W = (timeout > 1) ? $clog2(timeout) : 1;

    logic [GAP_W-1:0] r_gap;

    assign o_expire = i_fill && !i_valid && (r_gap == GAP_W'(timeout - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap <= '0;
        end else if (!i_fill || i_valid || o_expire) begin
            r_gap <= '0;
        end else begin
            r_gap <= r_gap + 1'b1;
        end
    end

endmodule

// File: rtl/layer_deser.sv
// Serial-to-parallel frame collector: gathers `words` stream words into one
// packed frame. Optional idle-gap abort is enabled by LAYER_DESER_TIMEOUT_EN.
module layer_deser
    import net_pkg::*;
#(
    parameter int dataWidth = DATA_WIDTH,
    parameter int words     = LAYER0_NEURONS,
    parameter int timeout   = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [dataWidth-1:0]       in_data,
    output logic                       out_valid,
    output logic [words*dataWidth-1:0] out_data,
    output logic                       busy,
    output logic                       frame_err
);

    localparam int                CNT_W    = (words > 1) ? $clog2(words) : 1;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(words - 1);

    state_t                     r_state;
    state_t                     w_next;
    logic [CNT_W-1:0]           r_cnt;
    logic [CNT_W-1:0]           w_idx;
    logic [words*dataWidth-1:0] r_buf;
    logic [words*dataWidth-1:0] r_out;
    logic [words*dataWidth-1:0] w_frame;
    logic                       r_out_valid;
    logic                       w_last;
    logic                       w_expire;

    // In IDLE the incoming word is always word 0, so a one-word frame completes at once.
    assign w_idx  = (r_state == ST_FILL) ? r_cnt : '0;
    assign w_last = in_valid && (w_idx == LAST_IDX);

    assign busy      = (r_state == ST_FILL);
    assign out_valid = r_out_valid;
    assign out_data  = r_out;

    // NOTE: defaults first in every combinational block, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        w_frame = r_buf;
        w_frame[w_idx*dataWidth +: dataWidth] = in_data;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid && !w_last)  w_next = ST_FILL;
            ST_FILL: if (w_last || w_expire)   w_next = ST_IDLE;
            default:                           w_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: the frame buffers are reset on purpose: after reset both the partial
    // frame and the published frame must read as all zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_buf       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_last;
            if (in_valid) begin
                r_buf[w_idx*dataWidth +: dataWidth] <= in_data;
                r_cnt <= w_last ? '0 : w_idx + 1'b1;
            end else if (w_expire) begin
                r_cnt <= '0;
            end
            if (w_last) begin
                r_out <= w_frame;
            end
        end
    end

`ifdef LAYER_DESER_TIMEOUT_EN
    logic r_frame_err;

    layer_deser_gap_timer #(
        .timeout (timeout)
    ) u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_fill   (busy),
        .i_valid  (in_valid),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_expire;
        end
    end

    assign frame_err = r_frame_err;
`else
    assign w_expire  = 1'b0;
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_layer_deser.sv
// Directed bench for layer_deser: a 30-word instance plus a 1-word instance.
// The timeout scenario runs when LAYER_DESER_TIMEOUT_EN is defined.
module tb_layer_deser;

    localparam int DW = 16;
    localparam int NW = 30;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic [DW-1:0]      in_data;
    logic               out_valid;
    logic [NW*DW-1:0]   out_data;
    logic               busy;
    logic               frame_err;

    logic               in_valid1;
    logic [DW-1:0]      in_data1;
    logic               out_valid1;
    logic [DW-1:0]      out_data1;
    logic               busy1;
    logic               frame_err1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    layer_deser #(.dataWidth(DW), .words(NW), .timeout(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .frame_err (frame_err)
    );

    layer_deser #(.dataWidth(DW), .words(1), .timeout(8)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_data   (in_data1),
        .out_valid (out_valid1),
        .out_data  (out_data1),
        .busy      (busy1),
        .frame_err (frame_err1)
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_valid1 = 1'b0; in_data1 = '0;
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        total++; if (out_data1 !== '0 || out_valid1 !== 1'b0) begin bad++; $display("FAIL reset_dut1 got=%h/%b want=0/0", out_data1, out_valid1); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_consecutive();
        logic [NW*DW-1:0] exp;
        int early = 0;
        int not_busy = 0;
        for (int k = 0; k < NW; k++) exp[k*DW +: DW] = DW'(k + 1);
        for (int k = 0; k < NW; k++) begin
            send(DW'(k + 1));
            if (k < NW - 1) begin
                if (out_valid) early++;
                if (!busy) not_busy++;
            end
        end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL consec_pulse got=%b want=1", out_valid); end
        total++; if (out_data !== exp) begin bad++; $display("FAIL consec_data got=%h want=%h", out_data, exp); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL consec_busy_done got=%b want=0", busy); end
        total++; if (early !== 0 || not_busy !== 0) begin bad++; $display("FAIL consec_during early=%0d not_busy=%0d want 0/0", early, not_busy); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL consec_single_pulse got=%b want=0", out_valid); end
        total++; if (out_data !== exp) begin bad++; $display("FAIL consec_hold got=%h want=%h", out_data, exp); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL consec_frame_err got=%b want=0", frame_err); end
    endtask

    task automatic test_back_to_back();
        logic [NW*DW-1:0] exp_a;
        logic [NW*DW-1:0] exp_b;
        int p1 = -1;
        int p2 = -1;
        int pulses = 0;
        int hold_err = 0;
        for (int k = 0; k < NW; k++) begin
            exp_a[k*DW +: DW] = DW'(16'h1000 + k);
            exp_b[k*DW +: DW] = DW'(16'h2000 + k);
        end
        for (int s = 0; s < 2 * NW; s++) begin
            in_valid = 1'b1;
            in_data  = (s < NW) ? DW'(16'h1000 + s) : DW'(16'h2000 + s - NW);
            step();
            if (out_valid) begin
                pulses++;
                if (p1 < 0) p1 = s; else p2 = s;
            end
            if (s >= NW - 1 && s < 2 * NW - 1 && out_data !== exp_a) hold_err++;
        end
        in_valid = 1'b0;
        total++; if (pulses !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d want=2", pulses); end
        total++; if (p1 !== NW - 1 || p2 - p1 !== NW) begin bad++; $display("FAIL b2b_spacing p1=%0d p2=%0d want %0d/%0d", p1, p2, NW - 1, 2 * NW - 1); end
        total++; if (hold_err !== 0) begin bad++; $display("FAIL b2b_hold_a bad_cycles=%0d want=0", hold_err); end
        total++; if (out_data !== exp_b) begin bad++; $display("FAIL b2b_data_b got=%h want=%h", out_data, exp_b); end
        step();
    endtask

    task automatic test_gaps();
        logic [NW*DW-1:0] exp;
        int gap_bad = 0;
        for (int k = 0; k < NW; k++) exp[k*DW +: DW] = DW'(k + 1);
        for (int k = 0; k < NW; k++) begin
            if (k > 0) begin
                for (int g = 0; g < (k * 7 + 3) % 6; g++) begin
                    in_data = 16'hBEEF;
                    step();
                    if (busy !== 1'b1 || out_valid !== 1'b0) gap_bad++;
                end
            end
            send(DW'(k + 1));
            if (k < NW - 1 && (busy !== 1'b1 || out_valid !== 1'b0)) gap_bad++;
        end
        total++; if (gap_bad !== 0) begin bad++; $display("FAIL gaps_busy bad_cycles=%0d want=0", gap_bad); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL gaps_pulse got=%b want=1", out_valid); end
        total++; if (out_data !== exp) begin bad++; $display("FAIL gaps_data got=%h want=%h", out_data, exp); end
        step();
    endtask

    task automatic test_reset_mid();
        logic [NW*DW-1:0] exp;
        int pulses = 0;
        for (int k = 0; k < NW; k++) exp[k*DW +: DW] = 16'hAAAA;
        for (int k = 0; k < 12; k++) send(DW'(16'h5500 + k));
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL rstmid_out_data got=%h want=0", out_data); end
        #1 rst_n = 1'b1;
        step();
        for (int k = 0; k < NW; k++) begin
            send(16'hAAAA);
            if (out_valid) pulses++;
        end
        total++; if (out_data !== exp) begin bad++; $display("FAIL rstmid_data got=%h want=%h", out_data, exp); end
        repeat (3) begin
            step();
            if (out_valid) pulses++;
        end
        total++; if (pulses !== 1) begin bad++; $display("FAIL rstmid_pulses got=%0d want=1", pulses); end
    endtask

    task automatic test_single_word();
        in_valid1 = 1'b1;
        in_data1  = 16'h0005;
        step();
        total++; if (out_valid1 !== 1'b1 || out_data1 !== 16'h0005) begin bad++; $display("FAIL single_w0 got=%b/%h want=1/0005", out_valid1, out_data1); end
        in_data1 = 16'h0006;
        step();
        total++; if (out_valid1 !== 1'b1 || out_data1 !== 16'h0006) begin bad++; $display("FAIL single_w1 got=%b/%h want=1/0006", out_valid1, out_data1); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL single_busy got=%b want=0", busy1); end
        in_valid1 = 1'b0;
        in_data1  = 16'h0077;
        step();
        total++; if (out_valid1 !== 1'b0 || out_data1 !== 16'h0006) begin bad++; $display("FAIL single_idle got=%b/%h want=0/0006", out_valid1, out_data1); end
    endtask

`ifdef LAYER_DESER_TIMEOUT_EN
    task automatic test_timeout();
        logic [NW*DW-1:0] prev;
        logic [NW*DW-1:0] exp;
        int err_at = -1;
        int errs = 0;
        int pulses = 0;
        for (int k = 0; k < NW; k++) begin
            prev[k*DW +: DW] = 16'hAAAA;
            exp[k*DW +: DW]  = DW'(16'h3000 + k);
        end
        for (int k = 0; k < 5; k++) send(DW'(16'h4000 + k));
        for (int g = 1; g <= 10; g++) begin
            step();
            if (frame_err) begin errs++; err_at = g; end
            if (out_valid) pulses++;
        end
        total++; if (errs !== 1 || err_at !== 8) begin bad++; $display("FAIL tmo_err count=%0d at=%0d want 1 at 8", errs, err_at); end
        total++; if (pulses !== 0 || busy !== 1'b0) begin bad++; $display("FAIL tmo_abort pulses=%0d busy=%b want 0/0", pulses, busy); end
        total++; if (out_data !== prev) begin bad++; $display("FAIL tmo_out_data got=%h want=%h", out_data, prev); end
        for (int k = 0; k < NW; k++) send(DW'(16'h3000 + k));
        total++; if (out_valid !== 1'b1 || out_data !== exp) begin bad++; $display("FAIL tmo_next got=%b/%h want=1/%h", out_valid, out_data, exp); end
        step();
    endtask
`else
    task automatic test_no_timeout();
        logic [NW*DW-1:0] exp;
        int err_seen = 0;
        int idle_bad = 0;
        for (int k = 0; k < NW; k++) exp[k*DW +: DW] = DW'(16'h3000 + k);
        for (int k = 0; k < 3; k++) send(DW'(16'h3000 + k));
        repeat (100) begin
            step();
            if (frame_err) err_seen++;
            if (busy !== 1'b1 || out_valid !== 1'b0) idle_bad++;
        end
        total++; if (err_seen !== 0) begin bad++; $display("FAIL notmo_frame_err got=%0d want=0", err_seen); end
        total++; if (idle_bad !== 0) begin bad++; $display("FAIL notmo_wait bad_cycles=%0d want=0", idle_bad); end
        for (int k = 3; k < NW; k++) send(DW'(16'h3000 + k));
        total++; if (out_valid !== 1'b1 || out_data !== exp) begin bad++; $display("FAIL notmo_done got=%b/%h want=1/%h", out_valid, out_data, exp); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_consecutive();
        test_back_to_back();
        test_gaps();
        test_reset_mid();
        test_single_word();
`ifdef LAYER_DESER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
